// File: rtl/if_stage.sv
// Instruction-fetch response stage between pre-IF and decode.
// Optional FS_STALL_CNT_EN adds the fs_stall_cnt output.

package if_stage_pkg;

  typedef struct packed {
    logic        tlb_refill;
    logic        inst_ok;
    logic [31:0] inst;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        ex;
    logic [31:0] pc;
  } pfs_fs_t;

  typedef struct packed {
    logic        tlb_refill;
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_ds_t;

endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned CANCEL_CNT_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pfs_to_fs_valid,
  input  logic [103:0] pfs_to_fs_bus,
  output logic         fs_allowin,
  output logic         fs_valid,
  output logic         fs_inst_unable,
  input  logic         inst_sram_data_ok,
  input  logic [31:0]  inst_sram_rdata,
  input  logic         pfs_inst_waiting,
  input  logic         ds_allowin,
  output logic         fs_to_ds_valid,
  output logic [102:0] fs_to_ds_bus,
`ifdef FS_STALL_CNT_EN
  output logic [31:0]  fs_stall_cnt,
`endif
  input  logic         do_flush
);

  localparam int unsigned CW = CANCEL_CNT_W;

  pfs_fs_t pfs_bus;
  fs_ds_t  ds_bus;

  logic        fs_ex;
  logic        fs_tlb_refill;
  logic [4:0]  fs_excode;
  logic [31:0] fs_badvaddr;
  logic [31:0] fs_pc;

  logic        inst_buf_valid;
  logic [31:0] inst_buf;

  logic [CW-1:0] cancel_cnt;
  logic [CW-1:0] cancel_nxt;
  logic [CW:0]   cnt_sum;
  logic          cnt_nz;
  logic          cnt_dec;

  logic        fs_owns;
  logic        fs_wait;
  logic        fs_inst_ok;
  logic        fs_ready_go;
  logic        fs_leave;
  logic        fs_load;
  logic        fs_capture;
  logic [31:0] fs_inst;

  assign pfs_bus = pfs_fs_t'(pfs_to_fs_bus);

  assign cnt_nz  = (cancel_cnt != '0);
  assign cnt_dec = inst_sram_data_ok && cnt_nz;

  // A response belongs to fs only when nothing squashed is still in flight
  assign fs_owns = fs_valid && !fs_ex
                && !inst_buf_valid && !cnt_nz;
  assign fs_wait = fs_owns && !inst_sram_data_ok;

  assign fs_inst_unable = !fs_owns && !cnt_nz;

  assign fs_inst_ok  = inst_buf_valid
                    || (fs_owns && inst_sram_data_ok);
  assign fs_ready_go = fs_ex || fs_inst_ok;
  assign fs_leave    = fs_ready_go && ds_allowin;
  assign fs_allowin  = !fs_valid || fs_leave;

  assign fs_to_ds_valid = fs_valid && fs_ready_go && !do_flush;

  assign fs_load = pfs_to_fs_valid && fs_allowin && !do_flush;

  // Hold the response only when ds cannot take it this cycle
  assign fs_capture = fs_owns && inst_sram_data_ok && !fs_leave;

  // Instruction word presented to ds; exception entries carry zero
  always_comb begin
    fs_inst = '0;
    if (fs_ex)
      fs_inst = '0;
    else if (inst_buf_valid)
      fs_inst = inst_buf;
    else
      fs_inst = inst_sram_rdata;
  end

  // Assemble the decode-stage bundle
  always_comb begin
    ds_bus            = '0;
    ds_bus.tlb_refill = fs_tlb_refill;
    ds_bus.ex         = fs_ex;
    ds_bus.excode     = fs_excode;
    ds_bus.badvaddr   = fs_badvaddr;
    ds_bus.inst       = fs_inst;
    ds_bus.pc         = fs_pc;
  end

  assign fs_to_ds_bus = ds_bus;

  // Squash count: flush adds requests left in flight, data_ok drains
  always_comb begin
    cnt_sum = {1'b0, cancel_cnt}
            - {{CW{1'b0}}, cnt_dec}
            + {{CW{1'b0}}, fs_wait}
            + {{CW{1'b0}}, pfs_inst_waiting};
    cancel_nxt = cancel_cnt;
    if (do_flush)
      cancel_nxt = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];
    else if (cnt_dec)
      cancel_nxt = cancel_cnt - CW'(1);
  end

  // Entry occupancy; a flush always empties the stage
  always_ff @(posedge clk) begin
    if (reset)
      fs_valid <= 1'b0;
    else if (do_flush)
      fs_valid <= 1'b0;
    else if (fs_allowin)
      fs_valid <= pfs_to_fs_valid;
  end

  // Latch pc and exception fields of an accepted entry
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_ex         <= 1'b0;
      fs_tlb_refill <= 1'b0;
      fs_excode     <= '0;
      fs_badvaddr   <= '0;
      fs_pc         <= '0;
    end else if (fs_load) begin
      fs_ex         <= pfs_bus.ex;
      fs_tlb_refill <= pfs_bus.tlb_refill;
      fs_excode     <= pfs_bus.excode;
      fs_badvaddr   <= pfs_bus.badvaddr;
      fs_pc         <= pfs_bus.pc;
    end
  end

  // Instruction buffer: from pfs on load, or from sram on a ds stall
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_buf_valid <= 1'b0;
      inst_buf       <= '0;
    end else if (do_flush) begin
      inst_buf_valid <= 1'b0;
    end else if (fs_load) begin
      inst_buf_valid <= pfs_bus.inst_ok;
      inst_buf       <= pfs_bus.inst;
    end else if (fs_allowin) begin
      inst_buf_valid <= 1'b0;
    end else if (fs_capture) begin
      inst_buf_valid <= 1'b1;
      inst_buf       <= inst_sram_rdata;
    end
  end

  // Squashed-response counter register
  always_ff @(posedge clk) begin
    if (reset)
      cancel_cnt <= '0;
    else
      cancel_cnt <= cancel_nxt;
  end

  // More squashed requests than the counter can hold is a protocol bug
  cancel_cnt_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(do_flush && cnt_sum[CW])
  );

`ifdef FS_STALL_CNT_EN
  // Cycles spent holding an entry that cannot yet go to ds
  always_ff @(posedge clk) begin
    if (reset)
      fs_stall_cnt <= '0;
    else if (fs_valid && !fs_ready_go)
      fs_stall_cnt <= fs_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
// Inputs change on negedge; outputs sampled 1 time unit later.

module tb_if_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         pfs_to_fs_valid;
  logic [103:0] pfs_to_fs_bus;
  logic         fs_allowin;
  logic         fs_valid;
  logic         fs_inst_unable;
  logic         inst_sram_data_ok;
  logic [31:0]  inst_sram_rdata;
  logic         pfs_inst_waiting;
  logic         ds_allowin;
  logic         fs_to_ds_valid;
  logic [102:0] fs_to_ds_bus;
  logic         do_flush;
`ifdef FS_STALL_CNT_EN
  logic [31:0]  fs_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int deliv;

  always #5 clk = ~clk;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .pfs_to_fs_valid   (pfs_to_fs_valid),
    .pfs_to_fs_bus     (pfs_to_fs_bus),
    .fs_allowin        (fs_allowin),
    .fs_valid          (fs_valid),
    .fs_inst_unable    (fs_inst_unable),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .pfs_inst_waiting  (pfs_inst_waiting),
    .ds_allowin        (ds_allowin),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
`ifdef FS_STALL_CNT_EN
    .fs_stall_cnt      (fs_stall_cnt),
`endif
    .do_flush          (do_flush)
  );

  function automatic logic [103:0] mk_pfs(
    input logic        tlb,
    input logic        ok,
    input logic [31:0] inst,
    input logic [4:0]  exc,
    input logic [31:0] bva,
    input logic        ex,
    input logic [31:0] pc
  );
    return {tlb, ok, inst, exc, bva, ex, pc};
  endfunction

  function automatic logic [102:0] mk_ds(
    input logic        tlb,
    input logic        ex,
    input logic [4:0]  exc,
    input logic [31:0] bva,
    input logic [31:0] inst,
    input logic [31:0] pc
  );
    return {tlb, ex, exc, bva, inst, pc};
  endfunction

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    pfs_to_fs_valid   = 1'b0;
    pfs_to_fs_bus     = '0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = '0;
    pfs_inst_waiting  = 1'b0;
    ds_allowin        = 1'b1;
    do_flush          = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    nxt(); #1;
    chk("rst_fs_valid", fs_valid, 1'b0);
    chk("rst_allowin", fs_allowin, 1'b1);
    chk("rst_to_ds_valid", fs_to_ds_valid, 1'b0);
    chk("rst_inst_unable", fs_inst_unable, 1'b1);

    // 1: instruction already present on the pfs bus
    nxt();
    reset           = 1'b0;
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_bus   = mk_pfs(1'b0, 1'b1, 32'h24010001,
                             5'd0, 32'd0, 1'b0, 32'hbfc00000);
    #1;
    chk("t1_allowin", fs_allowin, 1'b1);
    nxt();
    pfs_to_fs_valid = 1'b0;
    #1;
    chk("t1_valid", fs_to_ds_valid, 1'b1);
    chk("t1_bus", fs_to_ds_bus,
        mk_ds(1'b0, 1'b0, 5'd0, 32'd0, 32'h24010001, 32'hbfc00000));
    chk("t1_unable", fs_inst_unable, 1'b1);

    // 2: fs collects data_ok three cycles after the load
    nxt();
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_bus   = mk_pfs(1'b0, 1'b0, 32'h0, 5'd0, 32'd0,
                             1'b0, 32'hbfc00004);
    #1;
    chk("t2_empty", fs_valid, 1'b0);
    nxt();
    pfs_to_fs_valid = 1'b0;
    #1;
    chk("t2_w1_unable", fs_inst_unable, 1'b0);
    chk("t2_w1_valid", fs_to_ds_valid, 1'b0);
    chk("t2_w1_allowin", fs_allowin, 1'b0);
    nxt(); #1;
    chk("t2_w2_unable", fs_inst_unable, 1'b0);
    nxt();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h8c220000;
    #1;
    chk("t2_dok_valid", fs_to_ds_valid, 1'b1);
    chk("t2_dok_bus", fs_to_ds_bus,
        mk_ds(1'b0, 1'b0, 5'd0, 32'd0, 32'h8c220000, 32'hbfc00004));
    chk("t2_dok_allowin", fs_allowin, 1'b1);
    nxt();
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    #1;
    chk("t2_gone", fs_valid, 1'b0);

    // 3: data arrives while ds stalls, buffered then delivered once
    nxt();
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_bus   = mk_pfs(1'b0, 1'b0, 32'h0, 5'd0, 32'd0,
                             1'b0, 32'hbfc00008);
    nxt();
    pfs_to_fs_valid   = 1'b0;
    ds_allowin        = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h8c220000;
    #1;
    chk("t3_dok_allowin", fs_allowin, 1'b0);
    nxt();
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h11111111;
    #1;
    chk("t3_buf_allowin", fs_allowin, 1'b0);
    chk("t3_buf_unable", fs_inst_unable, 1'b1);
    chk("t3_buf_bus", fs_to_ds_bus,
        mk_ds(1'b0, 1'b0, 5'd0, 32'd0, 32'h8c220000, 32'hbfc00008));
    repeat (4) nxt();
    deliv = 0;
    for (int i = 0; i < 5; i++) begin
      nxt();
      ds_allowin = 1'b1;
      #1;
      if (fs_to_ds_valid) deliv++;
      if (i == 0)
        chk("t3_deliver_bus", fs_to_ds_bus,
            mk_ds(1'b0, 1'b0, 5'd0, 32'd0,
                  32'h8c220000, 32'hbfc00008));
    end
    chk("t3_deliver_once", deliv, 1);

    // 4: flush with fs and pfs both waiting -> two responses dropped
    nxt();
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_bus   = mk_pfs(1'b0, 1'b0, 32'h0, 5'd0, 32'd0,
                             1'b0, 32'hbfc0000c);
    nxt();
    pfs_to_fs_valid  = 1'b0;
    do_flush         = 1'b1;
    pfs_inst_waiting = 1'b1;
    #1;
    chk("t4_flush_valid", fs_to_ds_valid, 1'b0);
    chk("t4_flush_unable", fs_inst_unable, 1'b0);
    nxt();
    do_flush         = 1'b0;
    pfs_inst_waiting = 1'b0;
    #1;
    chk("t4_idle_valid", fs_valid, 1'b0);
    chk("t4_idle_unable", fs_inst_unable, 1'b0);
    nxt();
    inst_sram_data_ok = 1'b1;
    #1;
    chk("t4_drop1_unable", fs_inst_unable, 1'b0);
    chk("t4_drop1_valid", fs_to_ds_valid, 1'b0);
    nxt(); #1;
    chk("t4_drop2_unable", fs_inst_unable, 1'b0);
    nxt(); #1;
    chk("t4_third_unable", fs_inst_unable, 1'b1);
    nxt();
    inst_sram_data_ok = 1'b0;

    // 5: exception entry forwards without waiting for data
    nxt();
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_bus   = mk_pfs(1'b1, 1'b0, 32'hdeadbeef, 5'h02,
                             32'h00400000, 1'b1, 32'h00400000);
    nxt();
    pfs_to_fs_valid = 1'b0;
    #1;
    chk("t5_valid", fs_to_ds_valid, 1'b1);
    chk("t5_bus", fs_to_ds_bus,
        mk_ds(1'b1, 1'b1, 5'h02, 32'h00400000, 32'h0, 32'h00400000));
    chk("t5_unable", fs_inst_unable, 1'b1);

    // 6: flush coincides with fs's own data_ok -> nothing squashed
    nxt();
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_bus   = mk_pfs(1'b0, 1'b0, 32'h0, 5'd0, 32'd0,
                             1'b0, 32'hbfc00010);
    nxt();
    pfs_to_fs_valid   = 1'b0;
    do_flush          = 1'b1;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h00000000;
    #1;
    chk("t6_flush_valid", fs_to_ds_valid, 1'b0);
    nxt();
    do_flush          = 1'b0;
    inst_sram_data_ok = 1'b0;
    #1;
    chk("t6_after_valid", fs_valid, 1'b0);
    chk("t6_after_unable", fs_inst_unable, 1'b1);
    nxt();
    inst_sram_data_ok = 1'b1;
    #1;
    chk("t6_cnt_zero", fs_inst_unable, 1'b1);
    nxt();
    inst_sram_data_ok = 1'b0;
    pfs_to_fs_valid   = 1'b1;
    pfs_to_fs_bus     = mk_pfs(1'b0, 1'b1, 32'h3c1d8000, 5'd0, 32'd0,
                               1'b0, 32'hbfc00014);
    nxt();
    pfs_to_fs_valid = 1'b0;
    #1;
    chk("t6_resume_bus", fs_to_ds_bus,
        mk_ds(1'b0, 1'b0, 5'd0, 32'd0, 32'h3c1d8000, 32'hbfc00014));
    chk("t6_resume_valid", fs_to_ds_valid, 1'b1);

    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
